multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter STATE_W, default 3, width of the state register and of the state output.
REQ-002 Port clk, input, 1, system clock; all state updates occur on the rising edge.
REQ-003 Port rst, input, 1, synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 Port instr, input, 32, current instruction word; held stable by the datapath from IF through WB.
REQ-005 Port zero, input, 1, ALU zero flag (combinational from the ALU), valid during EX.
REQ-006 Port alu_op, output, 4, ALU operation select driven to the ALU.
REQ-007 Port alu_src, output, 1, ALU operand 2 select: 0 = register rs2, 1 = immediate.
REQ-008 Port mem_read, output, 1, data memory read strobe.
REQ-009 Port mem_write, output, 1, data memory write strobe.
REQ-010 Port reg_write, output, 1, register file write enable.
REQ-011 Port mem_to_reg, output, 1, write-back select: 0 = ALU result, 1 = memory data.
REQ-012 Port load_pc, output, 1, PC register load enable.
REQ-013 Port pc_src, output, 1, PC next select: 0 = PC+4, 1 = branch target.
REQ-014 Port state, output, STATE_W, current FSM state, for debug.
REQ-015 Port illegal, output, 1, unsupported-opcode flag.

Function
REQ-016 Moore FSM states: IF=0, ID=1, EX=2, MEM=3, WB=4, HALT=5.
- Fixed sequence IF->ID->EX->MEM->WB->IF.
- Every legal or NOP instruction takes exactly 5 cycles.
REQ-017 The FSM registers decoded controls from instr on the ID->EX edge; EX, MEM and WB outputs use only these registered controls.
REQ-018 Supported opcodes:
- R-type 0110011
- I-ALU 0010011
- LW 0000011
- SW 0100011
- BEQ 1100011
REQ-019 R/I alu_op by funct3:
- 000: ADD 0010; SUB 0110 when R-type and funct7[5]=1
- 001: LSL 1001
- 010: LT 0111
- 100: XOR 1101
- 101: LSR 1000; ASR 1010 when funct7[5]=1
- 110: OR 0001
- 111: AND 0000
REQ-020 LW/SW use alu_op ADD; BEQ uses alu_op SUB.
REQ-021 alu_src=1 for I-ALU, LW and SW, and 0 otherwise; alu_op and alu_src hold during EX, MEM and WB, and are 0 in IF and ID.
REQ-022 mem_read=1 only in MEM for LW; mem_write=1 only in MEM for SW.
REQ-023 In WB:
- reg_write=1 for R-type, I-ALU and LW.
- mem_to_reg=1 for LW only.
REQ-024 Branch taken flag (BEQ && zero) is registered on the EX->MEM edge.
- pc_src equals this flag during WB; 0 otherwise.
REQ-025 load_pc=1 only in WB, exactly one cycle per instruction.
REQ-026 Unsupported opcode: all strobes are 0 (NOP), except that load_pc still pulses in WB; illegal=1 from EX until the next IF (behaviour without the macro; see REQ-030).
REQ-027 Strobes are never asserted in IF or ID.

Reset
REQ-028 On rst=1 at a clock edge, regardless of state, the FSM enters IF on that edge.
- All outputs and registered decode are 0; state=0.
- Reset overrides HALT.
REQ-029 Reset mid-instruction (e.g. during MEM of SW) discards the instruction: no mem_write or load_pc is asserted after the reset edge.

Configuration
REQ-030 Macro ILLEGAL_TRAP_EN:
- Defined: an unsupported opcode moves EX->HALT; HALT holds all strobes at 0 and illegal=1, and leaves only on rst.
- Undefined: HALT is unreachable and unsupported opcodes behave as in REQ-026.

Verification
REQ-031 R-type SUB (funct7=0100000, funct3=000) -> EX..WB: alu_op=0110, alu_src=0; WB: reg_write=1, load_pc=1, pc_src=0; 5 cycles total.
REQ-032 LW then SW -> LW: mem_read=1 in MEM, mem_to_reg=1 and reg_write=1 in WB; SW: mem_write=1 in MEM, reg_write=0; both alu_op=0010, alu_src=1.
REQ-033 BEQ with zero=1 in EX, then BEQ with zero=0 -> first: pc_src=1 in WB; second: pc_src=0; both alu_op=0110 and load_pc=1 in WB.
REQ-034 rst asserted in MEM of SW -> next cycle state=IF, mem_write=0, load_pc=0, all outputs 0.
REQ-035 Opcode 1111111 -> without macro: illegal=1 in EX..WB, no strobes, returns to IF; with ILLEGAL_TRAP_EN: state=5 held for 20 cycles until rst.
REQ-036 I-ALU funct3=101 with funct7[5]=1, then funct7[5]=0 -> alu_op=1010, then 1000; alu_src=1 for both.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for a five-step multicycle RISC-V-style
// datapath. The sequence is IF -> ID -> EX -> MEM -> WB -> IF.
// Decode is captured on the ID->EX edge. From EX to WB the outputs are driven
// only from that captured decode, so the instruction word can change as soon
// as WB retires.
// Optional build macro: ILLEGAL_TRAP_EN. When it is defined, an unsupported
// opcode traps into HALT from EX, and only rst leaves HALT. When it is not
// defined, an unsupported opcode runs as a NOP and still pulses load_pc in WB.

module multicycle_ctrl #(
  parameter int STATE_W = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               zero,
  output logic [3:0]         alu_op,
  output logic               alu_src,
  output logic               mem_read,
  output logic               mem_write,
  output logic               reg_write,
  output logic               mem_to_reg,
  output logic               load_pc,
  output logic               pc_src,
  output logic [STATE_W-1:0] state,
  output logic               illegal
);

  // FSM states; the numeric values are visible on the debug state port
  typedef enum logic [STATE_W-1:0] {
    S_IF   = STATE_W'(0),
    S_ID   = STATE_W'(1),
    S_EX   = STATE_W'(2),
    S_MEM  = STATE_W'(3),
    S_WB   = STATE_W'(4),
    S_HALT = STATE_W'(5)
  } state_t;

  // Supported major opcodes
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_IALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;

  // ALU operation codes
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_LT  = 4'b0111;
  localparam logic [3:0] ALU_LSR = 4'b1000;
  localparam logic [3:0] ALU_LSL = 4'b1001;
  localparam logic [3:0] ALU_ASR = 4'b1010;
  localparam logic [3:0] ALU_XOR = 4'b1101;

  state_t r_state;
  state_t w_next;

  // Registered decode, loaded on the ID->EX edge
  logic [3:0] r_alu_op;
  logic       r_alu_src;
  logic       r_is_load;
  logic       r_is_store;
  logic       r_is_beq;
  logic       r_reg_wr;
  logic       r_illegal;
  // Branch-taken flag, loaded on the EX->MEM edge
  logic       r_taken;

  // Combinational decode of the instruction word
  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_funct7b5;
  logic [3:0] w_dec_alu_op;
  logic       w_dec_alu_src;
  logic       w_dec_load;
  logic       w_dec_store;
  logic       w_dec_beq;
  logic       w_dec_reg_wr;
  logic       w_dec_illegal;
  logic       w_exec_phase;
  logic       w_unused;

  assign w_opcode   = instr[6:0];
  assign w_funct3   = instr[14:12];
  assign w_funct7b5 = instr[30];

  // Operand, register and immediate fields belong to the datapath only
  assign w_unused = ^{instr[31], instr[29:15], instr[11:7]};

  // funct3/funct7 to ALU operation for the R-type and I-ALU groups.
  // funct7[5] selects SUB only for R-type, because for I-ALU that bit is
  // immediate data. For shifts it selects ASR in both groups.
  function automatic logic [3:0] f_alu_fn(input logic [2:0] f3,
                                          input logic       f7b5,
                                          input logic       is_rtype);
    logic [3:0] v;
    case (f3)
      3'b000:  v = (is_rtype && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  v = ALU_LSL;
      3'b010:  v = ALU_LT;
      3'b100:  v = ALU_XOR;
      3'b101:  v = f7b5 ? ALU_ASR : ALU_LSR;
      3'b110:  v = ALU_OR;
      3'b111:  v = ALU_AND;
      default: v = ALU_ADD;   // funct3=011 has no dedicated ALU op here
    endcase
    return v;
  endfunction

  // Instruction decode: controls for the current instr word
  always_comb begin
    w_dec_alu_op  = '0;
    w_dec_alu_src = 1'b0;
    w_dec_load    = 1'b0;
    w_dec_store   = 1'b0;
    w_dec_beq     = 1'b0;
    w_dec_reg_wr  = 1'b0;
    w_dec_illegal = 1'b0;
    case (w_opcode)
      OP_RTYPE: begin
        w_dec_alu_op = f_alu_fn(w_funct3, w_funct7b5, 1'b1);
        w_dec_reg_wr = 1'b1;
      end
      OP_IALU: begin
        w_dec_alu_op  = f_alu_fn(w_funct3, w_funct7b5, 1'b0);
        w_dec_alu_src = 1'b1;
        w_dec_reg_wr  = 1'b1;
      end
      OP_LOAD: begin
        w_dec_alu_op  = ALU_ADD;
        w_dec_alu_src = 1'b1;
        w_dec_load    = 1'b1;
        w_dec_reg_wr  = 1'b1;
      end
      OP_STORE: begin
        w_dec_alu_op  = ALU_ADD;
        w_dec_alu_src = 1'b1;
        w_dec_store   = 1'b1;
      end
      OP_BEQ: begin
        w_dec_alu_op = ALU_SUB;
        w_dec_beq    = 1'b1;
      end
      default: begin
        w_dec_illegal = 1'b1;
      end
    endcase
  end

  // Capture the decode on the ID->EX edge. Reset clears the capture so a
  // discarded instruction leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_alu_op   <= '0;
      r_alu_src  <= 1'b0;
      r_is_load  <= 1'b0;
      r_is_store <= 1'b0;
      r_is_beq   <= 1'b0;
      r_reg_wr   <= 1'b0;
      r_illegal  <= 1'b0;
    end else if (r_state == S_ID) begin
      r_alu_op   <= w_dec_alu_op;
      r_alu_src  <= w_dec_alu_src;
      r_is_load  <= w_dec_load;
      r_is_store <= w_dec_store;
      r_is_beq   <= w_dec_beq;
      r_reg_wr   <= w_dec_reg_wr;
      r_illegal  <= w_dec_illegal;
    end
  end

  // Latch the branch decision from the ALU zero flag on the EX->MEM edge
  always_ff @(posedge clk) begin
    if (rst) begin
      r_taken <= 1'b0;
    end else if (r_state == S_EX) begin
      r_taken <= r_is_beq & zero;
    end
  end

  // State register; reset forces IF from any state, including HALT
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IF;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic: fixed five-step walk, with an optional trap out of EX
  always_comb begin
    w_next = S_IF;
    case (r_state)
      S_IF:  w_next = S_ID;
      S_ID:  w_next = S_EX;
      S_EX: begin
`ifdef ILLEGAL_TRAP_EN
        w_next = r_illegal ? S_HALT : S_MEM;
`else
        w_next = S_MEM;
`endif
      end
      S_MEM: w_next = S_WB;
      S_WB:  w_next = S_IF;
      S_HALT: begin
`ifdef ILLEGAL_TRAP_EN
        w_next = S_HALT;
`else
        w_next = S_IF;
`endif
      end
      default: w_next = S_IF;
    endcase
  end

  assign w_exec_phase = (r_state == S_EX) || (r_state == S_MEM) || (r_state == S_WB);

  // Moore outputs: built from the state and the captured decode only
  always_comb begin
    alu_op     = '0;
    alu_src    = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    load_pc    = 1'b0;
    pc_src     = 1'b0;
    illegal    = 1'b0;
    if (w_exec_phase) begin
      alu_op  = r_alu_op;
      alu_src = r_alu_src;
      illegal = r_illegal;
    end
    case (r_state)
      S_MEM: begin
        mem_read  = r_is_load;
        mem_write = r_is_store;
      end
      S_WB: begin
        reg_write  = r_reg_wr;
        mem_to_reg = r_is_load;
        load_pc    = 1'b1;
        pc_src     = r_taken;
      end
      S_HALT: begin
        illegal = 1'b1;
      end
      default: ;
    endcase
  end

  assign state = r_state;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A behavioural model computes,
// from the instruction class and the step number, what every output must be
// on every cycle. Directed cases with literal values pin the model.
// Randomised instructions then exercise the model against the design.
// ILLEGAL_TRAP_EN selects the trapping variant of the checks.

module tb_multicycle_ctrl;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_ILL = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic [3:0]  alu_op;
  logic        alu_src, mem_read, mem_write, reg_write, mem_to_reg;
  logic        load_pc, pc_src, illegal;
  logic [2:0]  state;
  logic [7:0]  ctl_dut;

  int tests = 0;
  int fails = 0;
  logic chk_en = 1'b0;

  // Model expectations for the current cycle
  logic [2:0] e_state;
  logic [3:0] e_op;
  logic [7:0] e_ctl;

  // DUT outputs captured per step of the last instruction
  logic [2:0] cap_st  [5];
  logic [3:0] cap_op  [5];
  logic [7:0] cap_ctl [5];

  multicycle_ctrl #(.STATE_W(3)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero),
    .alu_op(alu_op), .alu_src(alu_src), .mem_read(mem_read),
    .mem_write(mem_write), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
    .load_pc(load_pc), .pc_src(pc_src), .state(state), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // Control bits packed as {alu_src, mem_read, mem_write, reg_write,
  // mem_to_reg, load_pc, pc_src, illegal}
  assign ctl_dut = {alu_src, mem_read, mem_write, reg_write,
                    mem_to_reg, load_pc, pc_src, illegal};

  // Build an instruction word of a class. Unrelated fields are random.
  // For K_ILL, f7=1 forces opcode 1111111.
  function automatic logic [31:0] mk(input int kind, input logic [2:0] f3, input logic f7);
    logic [31:0] w;
    logic [6:0]  op;
    w = $urandom;
    case (kind)
      K_R:     op = 7'b0110011;
      K_I:     op = 7'b0010011;
      K_LW:    op = 7'b0000011;
      K_SW:    op = 7'b0100011;
      K_BEQ:   op = 7'b1100011;
      default: begin
        op = 7'($urandom);
        if (f7 || op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
            op == 7'b0100011 || op == 7'b1100011)
          op = 7'b1111111;
      end
    endcase
    w[6:0]   = op;
    w[14:12] = f3;
    w[30]    = f7;
    return w;
  endfunction

  // Expected outputs for step ph (0=IF .. 4=WB) of an instruction
  task automatic model(input int kind, input logic [2:0] f3, input logic f7,
                       input int ph, input logic tk);
    logic [3:0] tab [8];
    logic src, mr, mw, rw, m2r, lpc, pcs, ill;
    tab = '{4'b0010, 4'b1001, 4'b0111, 4'b0010, 4'b1101, 4'b1000, 4'b0001, 4'b0000};
    e_state = 3'(ph);
    e_op = 4'b0000;
    src = 0; mr = 0; mw = 0; rw = 0; m2r = 0; lpc = 0; pcs = 0; ill = 0;
    if (ph >= 2) begin
      case (kind)
        K_R, K_I: begin
          e_op = tab[f3];
          if (f3 == 3'd0 && kind == K_R && f7) e_op = 4'b0110;
          if (f3 == 3'd5 && f7) e_op = 4'b1010;
        end
        K_LW, K_SW: e_op = 4'b0010;
        K_BEQ:      e_op = 4'b0110;
        default:    e_op = 4'b0000;
      endcase
      src = (kind == K_I || kind == K_LW || kind == K_SW);
      ill = (kind == K_ILL);
    end
    mr  = (ph == 3) && (kind == K_LW);
    mw  = (ph == 3) && (kind == K_SW);
    rw  = (ph == 4) && (kind == K_R || kind == K_I || kind == K_LW);
    m2r = (ph == 4) && (kind == K_LW);
    lpc = (ph == 4);
    pcs = (ph == 4) && (kind == K_BEQ) && tk;
    e_ctl = {src, mr, mw, rw, m2r, lpc, pcs, ill};
  endtask

  task automatic lit(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%b required=%b", nm, act, exp);
    end
  endtask

  // Run one instruction from IF. Enters and leaves at posedge+1.
  // rst_ph >= 0 asserts reset during that step and abandons the instruction.
  task automatic run_instr(input int kind, input logic [2:0] f3, input logic f7,
                           input logic zex, input int rst_ph);
    int   last;
    logic tk;
    last = 4;
    tk = 1'b0;
`ifdef ILLEGAL_TRAP_EN
    if (kind == K_ILL) last = 2;
`endif
    for (int ph = 0; ph <= last; ph++) begin
      if (ph == 0) instr = mk(kind, f3, f7);
      zero = (ph == 2) ? zex : 1'($urandom);
      if (ph == 2) tk = (kind == K_BEQ) && zex;
      rst = (ph == rst_ph);
      model(kind, f3, f7, ph, tk);
      @(negedge clk); #1;
      cap_st[ph]  = state;
      cap_op[ph]  = alu_op;
      cap_ctl[ph] = ctl_dut;
      @(posedge clk); #1;
      if (ph == rst_ph) break;
    end
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      tests++;
      if ({state, alu_op, ctl_dut} !== {e_state, e_op, e_ctl}) begin
        fails++;
        $display("FAIL cycle t=%0t state=%0d/%0d alu_op=%b/%b ctl=%b/%b (actual/required)",
                 $time, state, e_state, alu_op, e_op, ctl_dut, e_ctl);
      end
    end
  end

  initial begin
    int kind;
    logic [2:0] f3;
    rst = 1'b1;
    instr = '0;
    zero = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    model(K_R, 3'd0, 1'b0, 0, 1'b0);
    chk_en = 1'b1;
    @(negedge clk); #1;
    lit("reset_state", 8'(state), 8'd0);
    lit("reset_ctl", ctl_dut, 8'b0);
    @(posedge clk); #1;

    // R-type SUB
    run_instr(K_R, 3'd0, 1'b1, 1'b0, -1);
    lit("sub_ex_op", 8'(cap_op[2]), 8'b0110);
    lit("sub_wb_op", 8'(cap_op[4]), 8'b0110);
    lit("sub_wb_ctl", cap_ctl[4], 8'b0001_0100);
    lit("sub_wb_state", 8'(cap_st[4]), 8'd4);

    // LW then SW
    run_instr(K_LW, 3'd2, 1'b0, 1'b0, -1);
    lit("lw_mem_ctl", cap_ctl[3], 8'b1100_0000);
    lit("lw_wb_ctl", cap_ctl[4], 8'b1001_1100);
    lit("lw_op", 8'(cap_op[3]), 8'b0010);
    run_instr(K_SW, 3'd2, 1'b0, 1'b0, -1);
    lit("sw_mem_ctl", cap_ctl[3], 8'b1010_0000);
    lit("sw_wb_ctl", cap_ctl[4], 8'b1000_0100);

    // BEQ taken, then not taken
    run_instr(K_BEQ, 3'd0, 1'b0, 1'b1, -1);
    lit("beq_taken_wb", cap_ctl[4], 8'b0000_0110);
    lit("beq_op", 8'(cap_op[4]), 8'b0110);
    run_instr(K_BEQ, 3'd0, 1'b0, 1'b0, -1);
    lit("beq_not_taken_wb", cap_ctl[4], 8'b0000_0100);

    // I-ALU shift right, arithmetic then logical
    run_instr(K_I, 3'd5, 1'b1, 1'b0, -1);
    lit("srai_op", 8'(cap_op[3]), 8'b1010);
    lit("srai_src", {7'b0, cap_ctl[3][7]}, 8'd1);
    run_instr(K_I, 3'd5, 1'b0, 1'b0, -1);
    lit("srli_op", 8'(cap_op[3]), 8'b1000);

    // Reset during MEM of SW discards it; the next cycle is a clean IF
    run_instr(K_SW, 3'd2, 1'b0, 1'b0, 3);
    lit("rst_mid_mem_wr_before", cap_ctl[3], 8'b1010_0000);
    run_instr(K_R, 3'd0, 1'b0, 1'b0, -1);
    lit("rst_mid_next_if_state", 8'(cap_st[0]), 8'd0);
    lit("rst_mid_next_if_ctl", cap_ctl[0], 8'b0);

    // Opcode 1111111
    run_instr(K_ILL, 3'd0, 1'b1, 1'b0, -1);
    lit("ill_ex_ctl", cap_ctl[2], 8'b0000_0001);
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 20; i++) begin
      e_state = 3'd5; e_op = 4'b0; e_ctl = 8'b0000_0001;
      zero = 1'($urandom);
      @(negedge clk); #1;
      cap_st[0] = state;
      @(posedge clk); #1;
    end
    lit("halt_held_state", 8'(cap_st[0]), 8'd5);
    rst = 1'b1;
    @(negedge clk); #1;
    @(posedge clk); #1;
    run_instr(K_R, 3'd7, 1'b0, 1'b0, -1);
    lit("after_halt_rst_state", 8'(cap_st[0]), 8'd0);
`else
    lit("ill_wb_ctl", cap_ctl[4], 8'b0000_0101);
    lit("ill_mem_op", 8'(cap_op[3]), 8'b0);
    run_instr(K_R, 3'd7, 1'b0, 1'b0, -1);
    lit("ill_back_to_if", 8'(cap_st[0]), 8'd0);
`endif

    // Randomised instruction stream
    for (int n = 0; n < 80; n++) begin
`ifdef ILLEGAL_TRAP_EN
      kind = int'($urandom_range(0, 4));
`else
      kind = int'($urandom_range(0, 5));
`endif
      f3 = 3'($urandom);
      if ((kind == K_R || kind == K_I) && f3 == 3'd3) f3 = 3'd0;
      if (n % 17 == 9)
        run_instr(kind, f3, 1'($urandom), 1'($urandom), int'($urandom_range(0, 4)));
      else
        run_instr(kind, f3, 1'($urandom), 1'($urandom), -1);
    end

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
